// File: rtl/myo_pwm_generator_if.sv
// Purpose: connects the PID controller to the H-bridge PWM stage (demand in; bridge drive, period tick and applied duty out).
// Latency: plain wires; timing is set by myo_pwm_generator.
// Backpressure: none; the master holds enable/pwmRef and the slave samples them at its own latch points.
interface myo_pwm_generator_if;
  logic               enable;
  logic signed [15:0] pwmRef;
  logic               pwm;
  logic               inA;
  logic               inB;
  logic               period_tick;
  logic signed [15:0] duty_active;

  modport master (
    output enable, pwmRef,
    input  pwm, inA, inB, period_tick, duty_active
  );

  modport slave (
    input  enable, pwmRef,
    output pwm, inA, inB, period_tick, duty_active
  );
endinterface

// File: rtl/myo_pwm_generator.sv
// Purpose: turns a signed pwmRef into an H-bridge triple (inA, inB, pwm). The demand is latched once per period and
//          a coast dead time is inserted on every reversal. Optional slew limit: define PWM_SLEW_LIMIT_EN.
// Latency: pwm/inA/inB are registered one clock behind the period counter. A latched demand applies from the next cnt=0.
// Backpressure: none; free-running. pwmRef is sampled only at latch points, and enable=0 idles the bridge on the next clock.
module myo_pwm_generator #(
  parameter int PERIOD_CNT  = 2500,
  parameter int MAX_DUTY    = 2400,
  parameter int DEAD_CYCLES = 50,
  parameter int SLEW_STEP   = 64
) (
  input  logic                clock,
  input  logic                reset,
  myo_pwm_generator_if.slave  bus
);

  localparam int CNT_W  = (PERIOD_CNT > 1) ? $clog2(PERIOD_CNT) : 1;
  localparam int DCNT_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PERIOD_CNT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEAD_CYCLES - 1);
  localparam logic [DCNT_W-1:0] DCNT_ONE  = DCNT_W'(1);
  localparam logic [16:0]       MAX_MAG   = 17'(MAX_DUTY);

`ifdef PWM_SLEW_LIMIT_EN
  localparam logic signed [17:0] SLEW_P = 18'(SLEW_STEP);
  localparam logic signed [17:0] SLEW_N = -SLEW_P;
`endif

  // FSM encoding kept as plain constants for compatibility with older tooling
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DEAD = 2'd2;

  // Refuse to elaborate with a parameter set the counters cannot represent
  if (PERIOD_CNT < 2 || PERIOD_CNT > 32768 || MAX_DUTY < 0 || MAX_DUTY > PERIOD_CNT ||
      DEAD_CYCLES < 1 || SLEW_STEP < 1) begin : g_bad_params
    $error("myo_pwm_generator: illegal parameter set");
  end

  // Architectural state
  logic [1:0]         state,  state_nxt;
  logic [CNT_W-1:0]   cnt,    cnt_nxt;
  logic [DCNT_W-1:0]  dcnt,   dcnt_nxt;
  logic               dir,    dir_nxt;     // 0 = forward (inA), 1 = reverse (inB)
  logic               pend_dir, pend_nxt;  // direction to adopt when the dead time ends
  logic signed [17:0] shadow, shadow_nxt;  // applied signed demand
  logic [16:0]        mag,    mag_nxt;     // |shadow|, compared against cnt

  // Registered outputs
  logic pwm_q, ina_q, inb_q, tick_q;
  logic pwm_nxt, ina_nxt, inb_nxt, tick_nxt;

  // Latch-point arithmetic
  logic signed [17:0] ref_s;
  logic [16:0]        ref_abs;
  logic [16:0]        ref_mag;
  logic signed [17:0] target;
  logic signed [17:0] lat_shadow;
  logic               lat_neg;
  logic [16:0]        lat_mag;
`ifdef PWM_SLEW_LIMIT_EN
  logic signed [17:0] diff;
`endif

  logic cnt_last;
  logic latch_pt;
  logic reversal;

  assign cnt_last = (cnt == CNT_LAST);
  // The IDLE->RUN clock is a latch point as well as the last clock of every period
  assign latch_pt = (state == ST_IDLE) || cnt_last;

  // Value the demand would take if latched this clock. -32768 needs the 17-bit magnitude.
  always_comb begin
    ref_s   = $signed({{2{bus.pwmRef[15]}}, bus.pwmRef});
    ref_abs = ref_s[17] ? 17'(-ref_s) : ref_s[16:0];
    ref_mag = (ref_abs > MAX_MAG) ? MAX_MAG : ref_abs;
    target  = ref_s[17] ? -$signed({1'b0, ref_mag}) : $signed({1'b0, ref_mag});
`ifdef PWM_SLEW_LIMIT_EN
    // shadow is 0 whenever we sit in IDLE, so the first latch after enable is slew-limited from zero
    diff = target - shadow;
    if (diff > SLEW_P) begin
      lat_shadow = shadow + SLEW_P;
    end else if (diff < SLEW_N) begin
      lat_shadow = shadow + SLEW_N;
    end else begin
      lat_shadow = target;
    end
`else
    lat_shadow = target;
`endif
    lat_neg = lat_shadow[17];
    lat_mag = lat_neg ? 17'(-lat_shadow) : lat_shadow[16:0];
  end

  // A zero demand never counts as a reversal; it keeps the current direction
  assign reversal = (lat_mag != '0) && (lat_neg != dir);

  // Next-state: period counter, demand latch, direction and dead-time sequencing
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    dcnt_nxt   = dcnt;
    dir_nxt    = dir;
    pend_nxt   = pend_dir;
    shadow_nxt = shadow;
    mag_nxt    = mag;
    if (!bus.enable) begin
      // dir is deliberately kept so that re-enabling against it still forces a dead time
      state_nxt  = ST_IDLE;
      cnt_nxt    = '0;
      dcnt_nxt   = '0;
      pend_nxt   = dir;
      shadow_nxt = '0;
      mag_nxt    = '0;
    end else begin
      cnt_nxt = (state == ST_IDLE || cnt_last) ? '0 : cnt + CNT_ONE;
      if (latch_pt) begin
        shadow_nxt = lat_shadow;
        mag_nxt    = lat_mag;
      end
      case (state)
        ST_IDLE, ST_RUN: begin
          if (latch_pt && reversal) begin
            state_nxt = ST_DEAD;
            dcnt_nxt  = DCNT_LAST;
            pend_nxt  = lat_neg;
          end else begin
            state_nxt = ST_RUN;
          end
        end
        ST_DEAD: begin
          // A demand latched mid-dead-time retargets the pending direction; zero means stay put
          if (latch_pt) begin
            pend_nxt = (lat_mag != '0) ? lat_neg : dir;
          end
          if (dcnt == '0) begin
            state_nxt = ST_RUN;
            dir_nxt   = pend_nxt;
          end else begin
            dcnt_nxt = dcnt - DCNT_ONE;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Output decode: the bridge is only driven in RUN, so a direction change always passes through all-off
  always_comb begin
    pwm_nxt  = bus.enable && (state == ST_RUN) && (17'(cnt) < mag);
    ina_nxt  = bus.enable && (state == ST_RUN) && !dir;
    inb_nxt  = bus.enable && (state == ST_RUN) && dir;
    // tick is aligned with cnt (not with pwm): it is high during the last clock of the period
    tick_nxt = (state_nxt != ST_IDLE) && (cnt_nxt == CNT_LAST);
  end

  // Control state registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      dcnt     <= '0;
      dir      <= 1'b0;
      pend_dir <= 1'b0;
      shadow   <= '0;
      mag      <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      dcnt     <= dcnt_nxt;
      dir      <= dir_nxt;
      pend_dir <= pend_nxt;
      shadow   <= shadow_nxt;
      mag      <= mag_nxt;
    end
  end

  // Output registers; the asynchronous reset drops the bridge immediately
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pwm_q  <= 1'b0;
      ina_q  <= 1'b0;
      inb_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      pwm_q  <= pwm_nxt;
      ina_q  <= ina_nxt;
      inb_q  <= inb_nxt;
      tick_q <= tick_nxt;
    end
  end

  assign bus.pwm         = pwm_q;
  assign bus.inA         = ina_q;
  assign bus.inB         = inb_q;
  assign bus.period_tick = tick_q;
  // |shadow| <= MAX_DUTY <= 32768, and +32768 cannot be requested, so 16 bits hold it
  assign bus.duty_active = shadow[15:0];

endmodule

// File: tb/tb_myo_pwm_generator.sv
// Purpose: self-checking bench for myo_pwm_generator: a per-cycle behavioural model plus directed period measurements.
// Latency: the model predicts the registered outputs for the clock after each edge; all checks sample on the falling edge.
// Backpressure: none; stimulus changes on falling edges and every wait is bounded.
module tb_myo_pwm_generator;

  localparam int P    = 2500;
  localparam int MAXD = 2400;
  localparam int D    = 50;
  localparam int SLEW = 64;

  logic clock = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  myo_pwm_generator_if bus ();

  myo_pwm_generator #(
    .PERIOD_CNT (P),
    .MAX_DUTY   (MAXD),
    .DEAD_CYCLES(D),
    .SLEW_STEP  (SLEW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Model state: on = not idle, pos = position in period, duty = applied signed demand,
  // dead = coast clocks still to run, pend = direction adopted when coasting ends
  int m_on = 0, m_pos = 0, m_duty = 0, m_dir = 0, m_dead = 0, m_pend = 0;
  int e_pwm = 0, e_ina = 0, e_inb = 0, e_tick = 0, e_duty = 0;

  // Behavioural model: predict the outputs visible after this edge, then advance the model
  always @(posedge clock or negedge reset) begin : model
    int mag, r, a, tgt, nd;
    bit lat, started;
    if (!reset) begin
      m_on = 0; m_pos = 0; m_duty = 0; m_dir = 0; m_dead = 0; m_pend = 0;
      e_pwm = 0; e_ina = 0; e_inb = 0; e_tick = 0; e_duty = 0;
    end else begin
      mag   = (m_duty < 0) ? -m_duty : m_duty;
      e_pwm = (bus.enable && m_on && m_dead == 0 && m_pos < mag) ? 1 : 0;
      e_ina = (bus.enable && m_on && m_dead == 0 && m_dir == 0) ? 1 : 0;
      e_inb = (bus.enable && m_on && m_dead == 0 && m_dir == 1) ? 1 : 0;
      if (!bus.enable) begin
        m_on = 0; m_pos = 0; m_duty = 0; m_dead = 0;
      end else begin
        lat     = (!m_on) || (m_pos == P - 1);
        started = 0;
        if (lat) begin
          r   = int'(bus.pwmRef);
          a   = (r < 0) ? -r : r;
          if (a > MAXD) a = MAXD;
          tgt = (r < 0) ? -a : a;
`ifdef PWM_SLEW_LIMIT_EN
          begin
            int dlt;
            dlt = tgt - m_duty;
            if (dlt > SLEW) dlt = SLEW;
            else if (dlt < -SLEW) dlt = -SLEW;
            nd = m_duty + dlt;
          end
`else
          nd = tgt;
`endif
          m_duty = nd;
          if (m_dead > 0) begin
            m_pend = (nd != 0) ? ((nd < 0) ? 1 : 0) : m_dir;
          end else if (nd != 0 && ((nd < 0) ? 1 : 0) != m_dir) begin
            m_dead  = D;
            m_pend  = (nd < 0) ? 1 : 0;
            started = 1;
          end
        end
        if (m_dead > 0 && !started) begin
          m_dead--;
          if (m_dead == 0) m_dir = m_pend;
        end
        m_pos = (!m_on || m_pos == P - 1) ? 0 : m_pos + 1;
        m_on  = 1;
      end
      e_tick = (bus.enable && m_pos == P - 1) ? 1 : 0;
      e_duty = m_duty;
    end
  end

  // Per-cycle compare against the model plus the bridge safety invariants
  logic [1:0] prev_ab = 2'b00;
  always @(negedge clock) begin
    tests++;
    if (bus.pwm !== 1'(e_pwm) || bus.inA !== 1'(e_ina) || bus.inB !== 1'(e_inb) ||
        bus.period_tick !== 1'(e_tick) || int'(bus.duty_active) != e_duty) begin
      fails++;
      $display("FAIL model @%0t: pwm/inA/inB/tick got %b%b%b%b want %0d%0d%0d%0d, duty got %0d want %0d",
               $time, bus.pwm, bus.inA, bus.inB, bus.period_tick, e_pwm, e_ina, e_inb, e_tick,
               int'(bus.duty_active), e_duty);
    end
    tests++;
    if ((bus.inA && bus.inB) || (prev_ab == 2'b10 && {bus.inA, bus.inB} == 2'b01) ||
        (prev_ab == 2'b01 && {bus.inA, bus.inB} == 2'b10)) begin
      fails++;
      $display("FAIL bridge @%0t: inA/inB went %b -> %b%b", $time, prev_ab, bus.inA, bus.inB);
    end
    prev_ab = {bus.inA, bus.inB};
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Returns on the falling edge where period_tick is high, or flags a timeout
  task automatic wait_tick();
    tests++;
    for (int i = 0; i < P + 500; i++) begin
      @(negedge clock);
      if (bus.period_tick) return;
    end
    fails++;
    $display("FAIL wait_tick: no period_tick within %0d clocks", P + 500);
  endtask

  // One full period starting just after a tick and ending on the next tick
  task automatic measure(output int highs, output int ticks, output int zeros);
    highs = 0; ticks = 0; zeros = 0;
    for (int i = 0; i < P; i++) begin
      @(negedge clock);
      highs += int'(bus.pwm);
      ticks += int'(bus.period_tick);
      if (!bus.pwm && !bus.inA && !bus.inB) zeros++;
    end
  endtask

  initial begin
    int h, t, z, n;
    reset = 1'b1; bus.enable = 1'b0; bus.pwmRef = '0;
    #1 reset = 1'b0;

    // T1: reset dominates an active enable and demand
    bus.enable = 1'b1; bus.pwmRef = 16'sd1000;
    repeat (3) @(negedge clock);
    check("rst_pwm", int'(bus.pwm), 0);
    check("rst_inA", int'(bus.inA), 0);
    check("rst_inB", int'(bus.inB), 0);
    check("rst_tick", int'(bus.period_tick), 0);
    check("rst_duty", int'(bus.duty_active), 0);
    reset = 1'b1;

`ifdef PWM_SLEW_LIMIT_EN
    // T6: 0 -> +1000 step ramps by 64 per period
    @(negedge clock);
    check("slew_first", int'(bus.duty_active), 64);
    for (int k = 2; k <= 16; k++) begin
      wait_tick();
      @(negedge clock);
      check("slew_step", int'(bus.duty_active), (64 * k < 1000) ? 64 * k : 1000);
    end
    check("slew_inA", int'(bus.inA), 1);
`else
    // T2: steady forward drive
    wait_tick();
    measure(h, t, z);
    check("t2_high", h, 1000);
    check("t2_ticks", t, 1);
    check("t2_inA", int'(bus.inA), 1);
    check("t2_inB", int'(bus.inB), 0);
    check("t2_duty", int'(bus.duty_active), 1000);

    // T4: reversal latched at the tick -> 50 coast clocks, then reverse
    bus.pwmRef = -16'sd1000;
    measure(h, t, z);
    check("t4_dead_high", h, 950);
    check("t4_dead_zeros", z, 50);
    check("t4_inA", int'(bus.inA), 0);
    check("t4_inB", int'(bus.inB), 1);
    check("t4_duty", int'(bus.duty_active), -1000);
    measure(h, t, z);
    check("t4_full_high", h, 1000);
    check("t4_full_zeros", z, 0);

    // T3: clamp, most negative input, zero demand
    bus.pwmRef = 16'sd5000;
    measure(h, t, z);
    check("t3_pos_rev_high", h, 2350);
    measure(h, t, z);
    check("t3_pos_clamp_high", h, 2400);
    check("t3_pos_inA", int'(bus.inA), 1);
    check("t3_pos_duty", int'(bus.duty_active), 2400);
    bus.pwmRef = 16'sh8000;
    measure(h, t, z);
    check("t3_min_rev_high", h, 2350);
    measure(h, t, z);
    check("t3_min_clamp_high", h, 2400);
    check("t3_min_inB", int'(bus.inB), 1);
    check("t3_min_duty", int'(bus.duty_active), -2400);
    bus.pwmRef = '0;
    measure(h, t, z);
    check("t3_zero_high", h, 0);
    check("t3_zero_inB", int'(bus.inB), 1);
    check("t3_zero_inA", int'(bus.inA), 0);
    check("t3_zero_duty", int'(bus.duty_active), 0);

    // T5: enable drop at cnt=500, then re-enable restarts the period at cnt 0
    bus.pwmRef = -16'sd1000;
    measure(h, t, z);
    check("t5_pre_high", h, 1000);
    repeat (501) @(negedge clock);
    bus.enable = 1'b0;
    @(negedge clock);
    check("t5_off_pwm", int'(bus.pwm), 0);
    check("t5_off_inA", int'(bus.inA), 0);
    check("t5_off_inB", int'(bus.inB), 0);
    check("t5_off_tick", int'(bus.period_tick), 0);
    check("t5_off_duty", int'(bus.duty_active), 0);
    repeat (3) @(negedge clock);
    bus.enable = 1'b1;
    h = 0; n = 0;
    for (int k = 1; k <= P; k++) begin
      @(negedge clock);
      h += int'(bus.pwm);
      if (bus.period_tick && n == 0) n = k;
    end
    check("t5_restart_high", h, 1000);
    check("t5_restart_tick_at", n, P);
    check("t5_restart_inB", int'(bus.inB), 1);
    measure(h, t, z);
    check("t5_next_high", h, 1000);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
